// File: rtl/control_filter.sv
// control_filter: sequencer for the one-pole low-pass filter datapath.
// Divides clk into a sample tick, clears filter history on note start or
// mode change, issues one update per tick and offers each filtered sample
// downstream through a valid/ready handshake.
// Optional build macro: FILTER_CTRL_OVERRUN_CNT_EN (saturating dropped-sample
// counter on overrun_count; tied to zero when undefined).
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_INIT   | post-reset, outputs idle, go clear the datapath
// S_CLEAR  | en=1 s=0: zero datapath history, apply requested filter mode
// S_IDLE   | waiting for a sample tick or a pending clear
// S_UPDATE | en=1 s=1: one filter update for the current tick
// S_VALID  | sample_valid=1, holding the sample until sample_ready
module control_filter #(
  parameter int CLK_DIV = 1042,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        note_start,
  input  logic        filter_choice_req,
  input  logic        sample_ready,
  output logic        en_filter,
  output logic        s_filter,
  output logic        filter_choice,
  output logic        sample_valid,
  output logic [15:0] overrun_count
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_CLEAR  = 3'd1,
    S_IDLE   = 3'd2,
    S_UPDATE = 3'd3,
    S_VALID  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             clear_pend;

  // Free-running sample divider; the FSM never restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_nxt    = S_INIT;
    en_filter    = 1'b0;
    s_filter     = 1'b0;
    sample_valid = 1'b0;
    case (state)
      S_INIT: begin
        state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        en_filter = 1'b1;
        state_nxt = S_IDLE;
      end
      S_IDLE: begin
        // A clear wins over a coincident tick; that tick is simply skipped.
        if (clear_pend || note_start) begin
          state_nxt = S_CLEAR;
        end else if (tick) begin
          state_nxt = S_UPDATE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_UPDATE: begin
        en_filter = 1'b1;
        s_filter  = 1'b1;
        state_nxt = S_VALID;
      end
      S_VALID: begin
        sample_valid = 1'b1;
        if (sample_ready) begin
          if (clear_pend) begin
            state_nxt = S_CLEAR;
          end else if (tick) begin
            state_nxt = S_UPDATE;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          // Not accepted: hold the old sample, any tick here is dropped.
          state_nxt = S_VALID;
        end
      end
      default: begin
        state_nxt = S_INIT;
      end
    endcase
  end

  // Pending-clear flag: remembers a note start or a mode mismatch until the
  // FSM can actually reach S_CLEAR (possibly after a handshake completes).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_pend <= 1'b0;
    end else if (state_nxt == S_CLEAR) begin
      clear_pend <= 1'b0;
    end else if (note_start || (filter_choice_req != filter_choice)) begin
      clear_pend <= 1'b1;
    end
  end

  // Applied mode is loaded on entry to S_CLEAR so the datapath clears with
  // the new mode already selected.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filter_choice <= 1'b1;
    end else if (state_nxt == S_CLEAR) begin
      filter_choice <= filter_choice_req;
    end
  end

`ifdef FILTER_CTRL_OVERRUN_CNT_EN
  logic overrun;

  // Overrun: a tick arrives while the previous sample is still unaccepted.
  always_comb begin
    overrun = (state == S_VALID) && !sample_ready && tick;
  end

  // Saturating dropped-sample counter, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_count <= 16'd0;
    end else if (overrun && (overrun_count != 16'hFFFF)) begin
      overrun_count <= overrun_count + 16'd1;
    end
  end
`else
  assign overrun_count = 16'd0;
`endif

endmodule

// File: tb/tb_control_filter.sv
// Testbench for control_filter with CLK_DIV=8: a sample-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_control_filter;

  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        note_start = 1'b0;
  logic        filter_choice_req = 1'b0;
  logic        sample_ready = 1'b1;
  logic        en_filter;
  logic        s_filter;
  logic        filter_choice;
  logic        sample_valid;
  logic [15:0] overrun_count;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

`ifdef FILTER_CTRL_OVERRUN_CNT_EN
  localparam int OVR_EN = 1;
`else
  localparam int OVR_EN = 0;
`endif

  control_filter #(.CLK_DIV(DIV), .CNT_W(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .note_start        (note_start),
    .filter_choice_req (filter_choice_req),
    .sample_ready      (sample_ready),
    .en_filter         (en_filter),
    .s_filter          (s_filter),
    .filter_choice     (filter_choice),
    .sample_valid      (sample_valid),
    .overrun_count     (overrun_count)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model in terms of what the datapath sees: a clear pulse, an
  // update pulse, or a held sample; the boot flag marks the first cycle.
  bit m_en, m_s, m_valid, m_fc, m_pend, m_boot;
  int m_ovr, m_cnt;

  always @(posedge clk or posedge reset) begin
    bit tick, go_clear, go_upd, hold;
    if (reset) begin
      m_en = 0; m_s = 0; m_valid = 0; m_fc = 1; m_pend = 0; m_boot = 1;
      m_ovr = 0; m_cnt = 0;
    end else begin
      tick = (m_cnt == DIV - 1);
      go_clear = 0; go_upd = 0; hold = 0;
      if (m_boot) go_clear = 1;
      else if (m_en && m_s) hold = 1;
      else if (m_en) ;
      else if (m_valid) begin
        if (sample_ready) begin
          if (m_pend) go_clear = 1;
          else if (tick) go_upd = 1;
        end else begin
          hold = 1;
          if (tick && m_ovr < 65535) m_ovr = m_ovr + 1;
        end
      end else begin
        if (m_pend || note_start) go_clear = 1;
        else if (tick) go_upd = 1;
      end
      m_pend = go_clear ? 0 : (m_pend || note_start || (filter_choice_req != m_fc));
      if (go_clear) m_fc = filter_choice_req;
      m_boot = 0;
      m_en = go_clear || go_upd;
      m_s = go_upd;
      m_valid = hold;
      m_cnt = (m_cnt + 1) % DIV;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("model en_filter", int'(en_filter), int'(m_en));
      chk("model s_filter", int'(s_filter), int'(m_s));
      chk("model sample_valid", int'(sample_valid), int'(m_valid));
      chk("model filter_choice", int'(filter_choice), int'(m_fc));
      chk("model overrun_count", int'(overrun_count), OVR_EN ? m_ovr : 0);
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " en"}, int'(en_filter), 0);
    chk({tag, " s"}, int'(s_filter), 0);
    chk({tag, " valid"}, int'(sample_valid), 0);
    chk({tag, " fc"}, int'(filter_choice), 1);
    chk({tag, " ovr"}, int'(overrun_count), 0);
  endtask

  initial begin
    int clears;
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int clears;
    repeat (3) @(negedge clk);
    chk_reset_outputs("in reset");
    reset = 0;

    // 1: boot sequence and steady cadence with ready=1
    chk("t1 c0 en", int'(en_filter), 0);
    wait_cyc(1);
    chk("t1 c1 clear en", int'(en_filter), 1);
    chk("t1 c1 clear s", int'(s_filter), 0);
    chk("t1 c1 fc", int'(filter_choice), 0);
    wait_cyc(8);
    chk("t1 c8 update", int'(en_filter && s_filter), 1);
    wait_cyc(9);
    chk("t1 c9 valid", int'(sample_valid), 1);
    wait_cyc(10);
    chk("t1 c10 valid drop", int'(sample_valid), 0);
    wait_cyc(16);
    chk("t1 c16 update", int'(en_filter && s_filter), 1);
    wait_cyc(17);
    chk("t1 c17 valid", int'(sample_valid), 1);

    // 2: stall ready for 20 cycles -> two overruns, then resume
    wait_cyc(25);
    chk("t2 c25 valid", int'(sample_valid), 1);
    sample_ready = 0;
    wait_cyc(44);
    chk("t2 c44 valid held", int'(sample_valid), 1);
    chk("t2 c44 overruns", int'(overrun_count), OVR_EN ? 2 : 0);
    wait_cyc(45);
    sample_ready = 1;
    wait_cyc(46);
    chk("t2 c46 transferred", int'(sample_valid), 0);
    wait_cyc(48);
    chk("t2 c48 update", int'(en_filter && s_filter), 1);
    sample_ready = 0;

    // 3: note_start while holding a sample
    wait_cyc(50);
    note_start = 1;
    wait_cyc(51);
    note_start = 0;
    wait_cyc(52);
    chk("t3 c52 still valid", int'(sample_valid), 1);
    chk("t3 c52 no clear yet", int'(en_filter), 0);
    wait_cyc(53);
    sample_ready = 1;
    wait_cyc(54);
    chk("t3 c54 clear", int'(en_filter && !s_filter), 1);
    wait_cyc(56);
    chk("t3 c56 update", int'(en_filter && s_filter), 1);

    // 4: note_start coincident with a tick in idle
    wait_cyc(63);
    chk("t4 c63 idle", int'(en_filter || sample_valid), 0);
    note_start = 1;
    wait_cyc(64);
    note_start = 0;
    chk("t4 c64 clear", int'(en_filter && !s_filter), 1);
    wait_cyc(65);
    chk("t4 c65 no update", int'(en_filter), 0);
    wait_cyc(72);
    chk("t4 c72 update", int'(en_filter && s_filter), 1);
    chk("t4 overruns unchanged", int'(overrun_count), OVR_EN ? 2 : 0);

    // 5: switch filter off mid-sample
    wait_cyc(76);
    filter_choice_req = 1;
    clears = 0;
    for (int c = 77; c <= 86; c++) begin
      wait_cyc(c);
      if (en_filter && !s_filter) clears++;
      if (c == 77) chk("t5 c77 fc old", int'(filter_choice), 0);
      if (c == 78) chk("t5 c78 fc new in clear", int'(filter_choice && en_filter), 1);
    end
    chk("t5 clear pulses", clears, 1);

    // 6: reset during update and during valid
    wait_cyc(88);
    chk("t6 c88 update", int'(en_filter && s_filter), 1);
    #2 reset = 1;
    #1 chk_reset_outputs("t6 reset in update");
    repeat (2) @(negedge clk);
    reset = 0;
    wait_cyc(1);
    chk("t6 restart clear", int'(en_filter && !s_filter), 1);
    wait_cyc(8);
    chk("t6 restart update", int'(en_filter && s_filter), 1);
    wait_cyc(9);
    chk("t6 restart valid", int'(sample_valid), 1);
    #2 reset = 1;
    #1 chk_reset_outputs("t6 reset in valid");
    repeat (2) @(negedge clk);
    reset = 0;
    wait_cyc(9);
    chk("t6 second restart valid", int'(sample_valid), 1);
    wait_cyc(10);
    chk("t6 second restart drop", int'(sample_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
